tetromino_draw_ctrl: RTL



---
 rtl/tetromino_draw_ctrl.sv | 256 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tetromino_draw_ctrl.sv
// ---------------------------------------------------------------------------
// tetromino_draw_ctrl
//
// Sequences tetromino redraws onto a 160x120 VGA frame buffer. Each accepted
// move request first erases the piece at its current location (if one is on
// screen) and then draws the requested piece at its new origin. Each pass
// walks the {row, col} sprite address space, absorbs the one-cycle piece-ROM
// read latency and emits clipped plot/x/y/colour writes.
//
// Ports
//   CLOCK_50        in   system clock, all state on posedge
//   Reset           in   asynchronous active-high reset
//   req             in   move request, sampled only in IDLE
//   req_erase_only  in   with req: erase current piece, draw nothing
//   req_x / req_y   in   new sprite origin
//   req_piece       in   new piece select
//   busy            out  high in every state except IDLE
//   done            out  one-cycle pulse in DONE
//   rom_addr        out  {row, col} address to the piece ROMs
//   rom_sel         out  piece select to the colour mux
//   rom_color       in   muxed ROM data, valid the cycle after rom_addr
//   vga_x / vga_y   out  pixel coordinate
//   vga_colour      out  pixel colour
//   plot            out  write strobe to the VGA adapter
// ---------------------------------------------------------------------------
module tetromino_draw_ctrl #(
    parameter int unsigned DIM_BITS  = 4,
    parameter int unsigned SCREEN_W  = 160,
    parameter int unsigned SCREEN_H  = 120,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    input  logic                  req,
    input  logic                  req_erase_only,
    input  logic [7:0]            req_x,
    input  logic [6:0]            req_y,
    input  logic [1:0]            req_piece,
    output logic                  busy,
    output logic                  done,
    output logic [2*DIM_BITS-1:0] rom_addr,
    output logic [1:0]            rom_sel,
    input  logic [2:0]            rom_color,
    output logic [7:0]            vga_x,
    output logic [6:0]            vga_y,
    output logic [2:0]            vga_colour,
    output logic                  plot
);

    localparam int unsigned AW = 2 * DIM_BITS;
    localparam int unsigned XW = 9;
    localparam int unsigned YW = 8;
    localparam logic [AW-1:0] CNT_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ERASE   = 3'd1,
        S_E_DRAIN = 3'd2,
        S_DRAW    = 3'd3,
        S_D_DRAIN = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   cnt_q;
    logic            drain_q;
    logic            erase_only_q;
    logic            busy_q;
    logic            done_q;
    logic [1:0]      rom_sel_q;

    logic [7:0]      cur_x_q;
    logic [6:0]      cur_y_q;
    logic [1:0]      cur_piece_q;
    logic            cur_valid_q;
    logic [7:0]      new_x_q;
    logic [6:0]      new_y_q;
    logic [1:0]      new_piece_q;

    // Stage register: coordinate and pass flags aligned with the ROM read
    logic [XW-1:0]   stg_x_q;
    logic [YW-1:0]   stg_y_q;
    logic            stg_act_q;
    logic            stg_erase_q;

    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      vga_colour_q;
    logic            plot_q;

    logic [DIM_BITS-1:0] row;
    logic [DIM_BITS-1:0] col;
    logic [7:0]          org_x;
    logic [6:0]          org_y;
    logic [XW-1:0]       pix_x_d;
    logic [YW-1:0]       pix_y_d;
    logic                pass_act_d;
    logic                on_screen;
    logic                plot_d;
    logic [2:0]          colour_d;

    // Pixel address generation for the address presented this cycle
    always_comb begin
        row        = cnt_q[AW-1:DIM_BITS];
        col        = cnt_q[DIM_BITS-1:0];
        org_x      = (state_q == S_ERASE) ? cur_x_q : new_x_q;
        org_y      = (state_q == S_ERASE) ? cur_y_q : new_y_q;
        // Widened sums so off-screen origins never wrap back onto the screen
        pix_x_d    = XW'(org_x) + XW'(col);
        pix_y_d    = YW'(org_y) + YW'(row);
        pass_act_d = (state_q == S_ERASE) || (state_q == S_DRAW);
    end

    // Plot decision once the ROM data for the staged address has arrived
    always_comb begin
        on_screen = (stg_x_q < XW'(SCREEN_W)) && (stg_y_q < YW'(SCREEN_H));
        plot_d    = stg_act_q && (rom_color != 3'b000) && on_screen;
        colour_d  = stg_erase_q ? BG_COLOUR : rom_color;
    end

    // Two-stage pixel pipeline: stage register, then output register
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            stg_x_q      <= '0;
            stg_y_q      <= '0;
            stg_act_q    <= 1'b0;
            stg_erase_q  <= 1'b0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            plot_q       <= 1'b0;
        end else begin
            stg_x_q      <= pix_x_d;
            stg_y_q      <= pix_y_d;
            stg_act_q    <= pass_act_d;
            stg_erase_q  <= (state_q == S_ERASE);
            vga_x_q      <= stg_x_q[7:0];
            vga_y_q      <= stg_y_q[6:0];
            vga_colour_q <= colour_d;
            plot_q       <= plot_d;
        end
    end

    // Control FSM with registered busy/done/rom_sel
    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            drain_q      <= 1'b0;
            erase_only_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rom_sel_q    <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            cur_piece_q  <= '0;
            cur_valid_q  <= 1'b0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            new_piece_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        erase_only_q <= req_erase_only;
                        cnt_q        <= '0;
                        busy_q       <= 1'b1;
                        if (!req_erase_only) begin
                            new_x_q     <= req_x;
                            new_y_q     <= req_y;
                            new_piece_q <= req_piece;
                        end
                        if (cur_valid_q) begin
                            state_q   <= S_ERASE;
                            rom_sel_q <= cur_piece_q;
                        end else if (req_erase_only) begin
                            // Nothing on screen to erase
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_DRAW;
                            rom_sel_q <= req_piece;
                        end
                    end
                end

                S_ERASE: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_E_DRAIN;
                        drain_q <= 1'b0;
                    end
                end

                S_E_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        if (erase_only_q) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= S_DRAW;
                            cnt_q     <= '0;
                            rom_sel_q <= new_piece_q;
                        end
                    end
                end

                S_DRAW: begin
                    cnt_q <= cnt_q + AW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_D_DRAIN;
                        drain_q <= 1'b0;
                    end
                end

                S_D_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end

                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (erase_only_q) begin
                        cur_valid_q <= 1'b0;
                    end else begin
                        cur_x_q     <= new_x_q;
                        cur_y_q     <= new_y_q;
                        cur_piece_q <= new_piece_q;
                        cur_valid_q <= 1'b1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rom_addr   = cnt_q;
    assign rom_sel    = rom_sel_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign plot       = plot_q;

endmodule
